// File: rtl/fb_sprite_blitter.sv
// Sprite blitter: walks a 16x8 ROM bitmap and writes one clipped pixel per clock
// into the framebuffer write port. Clear bitmap bits are transparent.
module fb_sprite_blitter #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 2,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [1:0]            sprite_id,
    input  logic [DATA_WIDTH-1:0] color,
    input  logic                  erase,
    output logic                  busy,
    output logic                  done,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] din_a
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAW, DONE} state_t;

    state_t                state;
    logic [2:0]            row;
    logic [3:0]            col;
    logic [9:0]            x_l;
    logic [9:0]            y_l;
    logic [1:0]            sid_l;
    logic [DATA_WIDTH-1:0] color_l;
    logic                  erase_l;
    logic [15:0]           rom_q;
    logic [10:0]           px;
    logic [10:0]           py;
    logic                  on_screen;

    function automatic logic [15:0] rom_row(input logic [1:0] id, input logic [2:0] r);
        logic [15:0] v;
        v = 16'h0000;
        case (id)
            2'd0: v = 16'hFFFF;
            2'd1: v = 16'h8001;
            2'd2: begin
                case (r)
                    3'd0: v = 16'h0810;
                    3'd1: v = 16'h0420;
                    3'd2: v = 16'h0FF0;
                    3'd3: v = 16'h1BD8;
                    3'd4: v = 16'h3FFC;
                    3'd5: v = 16'h2FF4;
                    3'd6: v = 16'h2814;
                    default: v = 16'h0660;
                endcase
            end
            default: begin
                case (r)
                    3'd0: v = 16'h03C0;
                    3'd1: v = 16'h1FF8;
                    3'd2: v = 16'h3FFC;
                    3'd3: v = 16'h399C;
                    3'd4: v = 16'h3FFC;
                    3'd5: v = 16'h0660;
                    3'd6: v = 16'h0DB0;
                    default: v = 16'h300C;
                endcase
            end
        endcase
        return v;
    endfunction

    // 11-bit sums so that x+col / y+row never wrap before the clip test
    assign px        = {1'b0, x_l} + {7'd0, col};
    assign py        = {1'b0, y_l} + {8'd0, row};
    assign on_screen = (int'(px) < H_RES) && (int'(py) < V_RES);

    // Command latch and registered ROM read; data only, no reset needed
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            x_l     <= x;
            y_l     <= y;
            sid_l   <= sprite_id;
            color_l <= color;
            erase_l <= erase;
        end
        if (state == FETCH) begin
            rom_q <= rom_row(sid_l, row);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            row    <= 3'd0;
            col    <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            we     <= 1'b0;
            addr_a <= '0;
            din_a  <= '0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row   <= 3'd0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    col   <= 4'd0;
                    state <= DRAW;
                end
                DRAW: begin
                    // ~col selects bit 15-col, so the MSB is the leftmost pixel
                    we     <= rom_q[~col] && on_screen;
                    addr_a <= ADDR_WIDTH'(py) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(px);
                    din_a  <= erase_l ? '0 : color_l;
                    col    <= col + 4'd1;
                    if (col == 4'd15) begin
                        if (row == 3'd7) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row   <= row + 3'd1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fb_sprite_blitter.md
# fb_sprite_blitter

Command-driven sprite blitter that sits directly upstream of the framebuffer dual-port RAM and drives its write port (`we`, `addr_a`, `din_a`). The game logic issues one draw or erase command (screen position, sprite id, colour). The block walks a 16x8 sprite bitmap from an internal ROM and writes one 2-bit pixel per clock into the framebuffer. Set bitmap bits are written; clear bits are transparent and are skipped. Off-screen pixels are clipped. VGA scanout reads the framebuffer independently through port b.

## Interface
- `ADDR_WIDTH`, default 22: framebuffer address width; must match the RAM.
- `DATA_WIDTH`, default 2: pixel width; must match the RAM.
- `H_RES`, default 640: visible columns; pixel address = y*H_RES + x.
- `V_RES`, default 480: visible rows.
- `clk`  in  1  system clock, shared with the framebuffer RAM.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `x`  in  10  left column of the sprite; latched on accept.
- `y`  in  10  top row of the sprite; latched on accept.
- `sprite_id`  in  2  selects one of 4 bitmaps; latched on accept.
- `color`  in  DATA_WIDTH  pixel value for draw mode; latched on accept.
- `erase`  in  1  1 = write 0 instead of `color`; latched on accept.
- `busy`  out  1  high while a command is executing.
- `done`  out  1  one-cycle pulse after the last pixel slot.
- `we`  out  1  framebuffer write enable (RAM `we`).
- `addr_a`  out  ADDR_WIDTH  framebuffer write address.
- `din_a`  out  DATA_WIDTH  framebuffer write data.

## Operation
- ROM: 4 sprites x 8 rows x 16 bits, registered read (1-cycle latency).
  - Bit [15-col] is column col, so the MSB is leftmost.
  - Sprite 0 is a solid block: every row is 16'hFFFF.
  - Sprite 1 row r = 16'h8001 for r = 0..7.
  - Sprites 2–3 hold invader art; their contents are not checked by the bench.
- FSM states: IDLE, FETCH, DRAW, DONE.
  - IDLE: on `start`=1, latch x, y, sprite_id, color and erase; set row=0; go to FETCH.
  - FETCH: issue the ROM read for the current row; set col=0; go to DRAW.
  - DRAW: one pixel slot per cycle, col = 0..15.
    - After col 15, if row < 7: row+1 and go to FETCH.
    - After col 15 of row 7: go to DONE.
  - DONE: `done`=1 for one cycle; go to IDLE.
- Pixel write in DRAW: `we`=1 only when all of the following hold:
  - the bitmap bit is 1;
  - (x+col) < H_RES;
  - (y+row) < V_RES.
- Write address and data:
  - `addr_a` = (y+row)*H_RES + (x+col), computed in ADDR_WIDTH bits with no truncation.
  - `din_a` = 0 when the latched `erase`=1, otherwise the latched `color`.
  - Draw with `color`=0 is legal and behaves like erase.
- `start` in any state other than IDLE is ignored and is not queued.
- Inputs may change freely after accept; only the latched copies are used.
- Clipping skips pixels only; the slot still consumes its cycle, so command length is fixed.
- `addr_a` and `din_a` are don't-care whenever `we`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `we`=0, `addr_a`=0, `din_a`=0, state IDLE, row=0, col=0.
- `busy` rises on the edge that accepts `start`.
- Each row takes 17 cycles (1 FETCH + 16 DRAW), so `busy` stays high for exactly 136 cycles.
- `done` is high during cycle 137 after the accept edge; `busy` is 0 during DONE.
- `we`, `addr_a` and `din_a` are registered and change together; the RAM captures them on the following edge.
- The earliest next accept is the IDLE cycle after DONE, so back-to-back commands have a 138-cycle period.
- Reset asserted mid-command: on the next edge `we`=0, `busy`=0, `done`=0, state IDLE. The partial sprite remains in the framebuffer and no `done` is issued.

## Test plan
- Sprite 0 at x=100, y=50, color=2'b11, draw → exactly 128 writes, first `addr_a`=32100, last `addr_a`=36595, all with `din_a`=3; `done` pulses 137 cycles after accept.
- Sprite 1 at x=0, y=0, color=2'b01 → 16 writes per sprite (2 per row) at addresses r*640 and r*640+15 for r=0..7; no other writes.
- Sprite 0 at x=632, y=476, draw → only cols 0..7 and rows 0..3 written (32 writes); `busy` still high for 136 cycles.
- Erase of sprite 0 at x=10, y=10 after a draw there → 128 writes with `din_a`=0; a framebuffer readback over port b returns 0 across the region.
- `start` pulsed at cycles 5 and 60 after an accept → second command ignored; exactly one `done` pulse and 128 writes.
- `reset` asserted at cycle 40 of a command → `we`=0 and `busy`=0 after the next edge; no `done`; a new `start` is then accepted normally.
